// File: rtl/ws2812b_pixel_fifo.sv
// Pixel feeder for the WS2812B serialiser: assembles G,R,B byte writes into
// 24-bit pixels and presents them through a small first-word-fall-through FIFO.
module ws2812b_pixel_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          wr_latch,
    output logic          wr_ready,
    input  logic          flush,
    output logic [23:0]   out_data,
    output logic          out_valid,
    output logic          out_latch,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic          underrun
);

    logic [1:0]  byte_idx;
    logic [7:0]  g_byte;
    logic [7:0]  r_byte;
    logic [24:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        frame_open;
    logic        full;
    logic        empty;
    logic        accept;
    logic        push;
    logic        pop;
    logic [24:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Only the B byte needs a free slot; a same-cycle pop does not help it.
    assign wr_ready = !((byte_idx == 2'd2) && full);
    assign accept   = wr_en && wr_ready && !flush;
    assign push     = accept && (byte_idx == 2'd2);
    assign pop      = !empty && out_ready && !flush;

    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_valid = !empty;
    assign out_data  = empty ? 24'd0 : head[23:0];
    assign out_latch = !empty && head[24];
    assign level     = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {wr_latch, g_byte, r_byte, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            byte_idx   <= 2'd0;
            g_byte     <= 8'd0;
            r_byte     <= 8'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            frame_open <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (accept) begin
                case (byte_idx)
                    2'd0:    g_byte <= wr_data;
                    2'd1:    r_byte <= wr_data;
                    default: ;
                endcase
                byte_idx <= (byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                frame_open <= !head[24];
            end
            // Serialiser asking for more while a frame is still open means the strip stalls.
            if (out_ready && empty && frame_open) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ws2812b_pixel_fifo.sv
// Scoreboard bench for ws2812b_pixel_fifo: pixels are queued as their B byte is
// accepted and compared against the FIFO head whenever the serialiser pops.
module tb_ws2812b_pixel_fifo;

    localparam int DEPTH = 4;
    localparam int AW = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'd0;
    logic          wr_latch = 1'b0;
    logic          wr_ready;
    logic          flush = 1'b0;
    logic [23:0]   out_data;
    logic          out_valid;
    logic          out_latch;
    logic          out_ready = 1'b0;
    logic [AW:0]   level;
    logic          underrun;

    int errors = 0;
    int checks = 0;
    int popped = 0;
    logic [24:0] sb [$];
    int          m_idx = 0;
    logic [7:0]  m_g = 8'd0;
    logic [7:0]  m_r = 8'd0;

    ws2812b_pixel_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .wr_latch(wr_latch), .wr_ready(wr_ready), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_latch(out_latch),
        .out_ready(out_ready), .level(level), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Any pop the DUT is about to perform must match the oldest queued pixel.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL pop_unexpected got=%h required=none", {out_latch, out_data});
            end else begin
                logic [24:0] exp;
                exp = sb.pop_front();
                popped++;
                if ({out_latch, out_data} !== exp) begin
                    errors++;
                    $display("[TB] FAIL pop_data got=%h required=%h", {out_latch, out_data}, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] d, input logic l);
        int waited;
        waited = 0;
        wr_en = 1'b1;
        wr_data = d;
        wr_latch = l;
        while (!wr_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!wr_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL put_byte_timeout got=wr_ready=0 required=1");
            wr_en = 1'b0;
            return;
        end
        case (m_idx)
            0: m_g = d;
            1: m_r = d;
            default: sb.push_back({l, m_g, m_r, d});
        endcase
        m_idx = (m_idx == 2) ? 0 : m_idx + 1;
        tick();
        wr_en = 1'b0;
        wr_latch = 1'b0;
    endtask

    task automatic put_pixel(input logic [23:0] p, input logic l);
        put_byte(p[23:16], 1'b0);
        put_byte(p[15:8], 1'b0);
        put_byte(p[7:0], l);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            while (!out_valid && w < 50) begin
                tick();
                w++;
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            tick();
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
        m_idx = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if ({out_valid, out_data, out_latch, level, underrun, wr_ready} !== {1'b0, 24'd0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_state got=v%b d%h l%b lvl%0d u%b r%b required=v0 d000000 l0 lvl0 u0 r1",
                     out_valid, out_data, out_latch, level, underrun, wr_ready);
        end
    endtask

    task automatic test_basic();
        put_pixel(24'h123456, 1'b1);
        checks++;
        if ({out_valid, out_data, out_latch, level} !== {1'b1, 24'h123456, 1'b1, 3'd1}) begin
            errors++;
            $display("[TB] FAIL basic_head got=v%b d%h l%b lvl%0d required=v1 d123456 l1 lvl1",
                     out_valid, out_data, out_latch, level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, level, underrun} !== {1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL basic_after_pop got=v%b lvl%0d u%b required=v0 lvl0 u0", out_valid, level, underrun);
        end
    endtask

    task automatic test_full();
        for (int p = 0; p < 4; p++) put_pixel(24'hA00000 + 24'(p * 24'h010203), 1'b0);
        checks++;
        if (level !== 3'd4) begin
            errors++;
            $display("[TB] FAIL full_level got=%0d required=4", level);
        end
        put_byte(8'hC1, 1'b0);
        put_byte(8'hC2, 1'b0);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_wr_ready got=%b required=0", wr_ready);
        end
        // Attempt the B byte while blocked; it must not land.
        wr_en = 1'b1;
        wr_data = 8'hEE;
        tick();
        tick();
        wr_en = 1'b0;
        checks++;
        if ({level, wr_ready} !== {3'd4, 1'b0}) begin
            errors++;
            $display("[TB] FAIL full_blocked got=lvl%0d r%b required=lvl4 r0", level, wr_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({level, wr_ready} !== {3'd3, 1'b1}) begin
            errors++;
            $display("[TB] FAIL full_after_pop got=lvl%0d r%b required=lvl3 r1", level, wr_ready);
        end
        put_byte(8'hC3, 1'b0);
        checks++;
        if (level !== 3'd4) begin
            errors++;
            $display("[TB] FAIL full_refill got=%0d required=4", level);
        end
        drain(4);
        checks++;
        if ({level, sb.size() == 0} !== {3'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL full_drain got=lvl%0d left%0d required=lvl0 left0", level, sb.size());
        end
        do_flush();
    endtask

    task automatic test_underrun();
        put_pixel(24'h010101, 1'b0);
        put_pixel(24'h020202, 1'b0);
        out_ready = 1'b1;
        tick();
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underrun_early got=%b required=0", underrun);
        end
        repeat (3) tick();
        out_ready = 1'b0;
        checks++;
        if ({underrun, level} !== {1'b1, 3'd0}) begin
            errors++;
            $display("[TB] FAIL underrun_set got=u%b lvl%0d required=u1 lvl0", underrun, level);
        end
        repeat (2) tick();
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underrun_sticky got=%b required=1", underrun);
        end
        do_flush();
        checks++;
        if ({underrun, level} !== {1'b0, 3'd0}) begin
            errors++;
            $display("[TB] FAIL underrun_flush got=u%b lvl%0d required=u0 lvl0", underrun, level);
        end
    endtask

    task automatic test_flush_partial();
        put_byte(8'hAA, 1'b0);
        put_byte(8'hBB, 1'b0);
        // A write presented alongside flush must be dropped as well.
        flush = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h77;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        sb.delete();
        m_idx = 0;
        put_pixel(24'h010203, 1'b0);
        checks++;
        if ({out_valid, out_data, level} !== {1'b1, 24'h010203, 3'd1}) begin
            errors++;
            $display("[TB] FAIL flush_partial got=v%b d%h lvl%0d required=v1 d010203 lvl1", out_valid, out_data, level);
        end
        drain(1);
        do_flush();
    endtask

    task automatic test_back_to_back();
        logic [23:0] pix [10];
        int start;
        int cyc;
        for (int p = 0; p < 10; p++) pix[p] = 24'($urandom);
        start = popped;
        fork
            begin
                for (int p = 0; p < 10; p++) put_pixel(pix[p], p == 9);
            end
            begin
                cyc = 0;
                while ((popped - start) < 10 && cyc < 1000) begin
                    if (out_ready) out_ready = 1'b0;
                    else out_ready = out_valid && ($urandom_range(0, 3) != 0);
                    checks++;
                    if (level > 3'(DEPTH)) begin
                        errors++;
                        $display("[TB] FAIL b2b_level got=%0d required<=%0d", level, DEPTH);
                    end
                    tick();
                    cyc++;
                end
                out_ready = 1'b0;
            end
        join
        checks++;
        if ((popped - start) != 10 || sb.size() != 0 || underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_count got=popped%0d left%0d u%b required=popped10 left0 u0",
                     popped - start, sb.size(), underrun);
        end
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 3; p++) put_pixel(24'h300000 + 24'(p), 1'b0);
        put_byte(8'h55, 1'b0);
        checks++;
        if (level !== 3'd3) begin
            errors++;
            $display("[TB] FAIL mid_level got=%0d required=3", level);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        m_idx = 0;
        checks++;
        if ({out_valid, out_data, out_latch, level, underrun, wr_ready} !== {1'b0, 24'd0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL mid_reset got=v%b d%h l%b lvl%0d u%b r%b required=v0 d000000 l0 lvl0 u0 r1",
                     out_valid, out_data, out_latch, level, underrun, wr_ready);
        end
        put_pixel(24'h0A0B0C, 1'b1);
        checks++;
        if ({out_data, out_latch} !== {24'h0A0B0C, 1'b1}) begin
            errors++;
            $display("[TB] FAIL mid_after_reset got=%h l%b required=0a0b0c l1", out_data, out_latch);
        end
        drain(1);
    endtask

    initial begin
        $display("[TB] starting ws2812b_pixel_fifo bench");
        test_reset();
        test_basic();
        test_full();
        test_underrun();
        test_flush_partial();
        test_back_to_back();
        test_reset_mid();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
